// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the DMA channel arbiter.
// State encoding for each arbiter side, plus a constant-foldable ceil(log2).
package dma_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_BUSY} arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One arbiter side: round-robin pick of req&ch_enable, held per burst, with watchdog.
// Latency: 1 cycle from eligible request to grant; zero-bubble regrant on done.
// Backpressure: grant held until start/done handshakes; dropped request before start withdraws it.
module rr_arbiter
    import dma_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int C_TIMEOUT = 1024,
    localparam int PW       = clog2(N),
    localparam int CH_W     = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    ch_enable,
    input  logic [N-1:0]    req,
    input  logic            start,
    input  logic            done,
    output logic            grant_valid,
    output logic [CH_W-1:0] active_channel,
    output logic            timeout
);

    localparam int            TW       = clog2(C_TIMEOUT + 1) + 1;
    localparam logic [TW-1:0] WD_LIMIT = TW'((C_TIMEOUT >= 2) ? C_TIMEOUT - 2 : 0);
    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

    arb_state_t    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ch;
    logic [PW-1:0] ch_adv;
    logic [TW-1:0] wd_cnt;
    logic [N-1:0]  elig;
    logic [PW:0]   pick_cur;
    logic [PW:0]   pick_adv;
    logic          expire;

    // Returns {found, index} of the first set bit at or after start_idx, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] mask, input logic [PW-1:0] start_idx);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(start_idx) + k;
            if (idx >= N) idx = idx - N;
            if (mask[PW'(idx)]) res = {1'b1, PW'(idx)};
        end
        return res;
    endfunction

    assign elig           = req & ch_enable;
    assign ch_adv         = (ch == LAST_IDX) ? '0 : ch + 1'b1;
    assign pick_cur       = rr_pick(elig, ptr);
    assign pick_adv       = rr_pick(elig, ch_adv);
    // wd_cnt is 0 in the first granted cycle, so the grant lives at most C_TIMEOUT-1 cycles
    assign expire         = (C_TIMEOUT > 0) && (wd_cnt >= WD_LIMIT);
    assign active_channel = {1'b0, ch};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            ptr         <= '0;
            ch          <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_cur[PW]) begin
                        state       <= ARB_GRANT;
                        ch          <= pick_cur[PW-1:0];
                        grant_valid <= 1'b1;
                        wd_cnt      <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (expire) begin
                        state       <= ARB_IDLE;
                        grant_valid <= 1'b0;
                        timeout     <= 1'b1;
                        ptr         <= ch_adv;
                    end else if (start) begin
                        state  <= ARB_BUSY;
                        wd_cnt <= wd_cnt + TW'(1);
                    end else if (!elig[ch]) begin
                        state       <= ARB_IDLE;
                        grant_valid <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + TW'(1);
                    end
                end
                ARB_BUSY: begin
                    if (done) begin
                        ptr <= ch_adv;
                        if (pick_adv[PW]) begin
                            state  <= ARB_GRANT;
                            ch     <= pick_adv[PW-1:0];
                            wd_cnt <= '0;
                        end else begin
                            state       <= ARB_IDLE;
                            grant_valid <= 1'b0;
                        end
                    end else if (expire) begin
                        state       <= ARB_IDLE;
                        grant_valid <= 1'b0;
                        timeout     <= 1'b1;
                        ptr         <= ch_adv;
                    end else begin
                        wd_cnt <= wd_cnt + TW'(1);
                    end
                end
                default: begin
                    state       <= ARB_IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Round-robin owner selection for the shared AXI read and write engines; sides are independent.
// Latency: 1 cycle request-to-grant, back-to-back regrant on burst completion.
// Backpressure: each grant is held until the engine finishes its burst or the watchdog fires.
module dma_channel_arbiter
    import dma_arb_pkg::*;
#(
    parameter int  C_M_NUM_CHANNELS = 4,
    parameter int  C_TIMEOUT        = 1024,
    localparam int CH_W             = clog2(C_M_NUM_CHANNELS) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [C_M_NUM_CHANNELS-1:0] ch_enable,
    input  logic [C_M_NUM_CHANNELS-1:0] r_req,
    input  logic [C_M_NUM_CHANNELS-1:0] w_req,
    input  logic                        r_start,
    input  logic                        r_done,
    input  logic                        w_start,
    input  logic                        w_done,
    output logic                        r_grant_valid,
    output logic                        w_grant_valid,
    output logic [CH_W-1:0]             r_active_channel,
    output logic [CH_W-1:0]             w_active_channel,
    output logic                        r_timeout,
    output logic                        w_timeout
);

    rr_arbiter #(
        .N         (C_M_NUM_CHANNELS),
        .C_TIMEOUT (C_TIMEOUT)
    ) u_rd_arb (
        .clk            (clk),
        .rst            (rst),
        .ch_enable      (ch_enable),
        .req            (r_req),
        .start          (r_start),
        .done           (r_done),
        .grant_valid    (r_grant_valid),
        .active_channel (r_active_channel),
        .timeout        (r_timeout)
    );

    rr_arbiter #(
        .N         (C_M_NUM_CHANNELS),
        .C_TIMEOUT (C_TIMEOUT)
    ) u_wr_arb (
        .clk            (clk),
        .rst            (rst),
        .ch_enable      (ch_enable),
        .req            (w_req),
        .start          (w_start),
        .done           (w_done),
        .grant_valid    (w_grant_valid),
        .active_channel (w_active_channel),
        .timeout        (w_timeout)
    );

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected outputs,
// a monitor pops and compares them one step after every rising edge.
module tb_dma_channel_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic         clk;
    logic         rst;
    logic [N-1:0] ch_enable;
    logic [N-1:0] r_req;
    logic [N-1:0] w_req;
    logic         r_start;
    logic         r_done;
    logic         w_start;
    logic         w_done;
    logic         r_grant_valid;
    logic         w_grant_valid;
    logic [2:0]   r_active_channel;
    logic [2:0]   w_active_channel;
    logic         r_timeout;
    logic         w_timeout;

    dma_channel_arbiter #(
        .C_M_NUM_CHANNELS (N),
        .C_TIMEOUT        (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ch_enable        (ch_enable),
        .r_req            (r_req),
        .w_req            (w_req),
        .r_start          (r_start),
        .r_done           (r_done),
        .w_start          (w_start),
        .w_done           (w_done),
        .r_grant_valid    (r_grant_valid),
        .w_grant_valid    (w_grant_valid),
        .r_active_channel (r_active_channel),
        .w_active_channel (w_active_channel),
        .r_timeout        (r_timeout),
        .w_timeout        (w_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: owner < 0 means nobody holds the engine.
    typedef struct {
        int owner;
        bit busy;
        int age;
        int ptr;
        int last;
        bit tmo;
    } side_t;

    typedef struct {
        int rv; int rc; int rt;
        int wv; int wc; int wt;
    } exp_t;

    exp_t  sbq[$];
    side_t rsd, wsd;
    int    total = 0;
    int    bad   = 0;
    bit    started = 0;

    // Stimulus variables applied by tick()
    bit         s_rst = 1;
    logic [3:0] s_en = 4'h0, s_rq = 4'h0, s_wq = 4'h0;
    bit         s_rs = 0, s_rd = 0, s_ws = 0, s_wd = 0;

    function automatic int bit_of(logic [3:0] v, int i);
        return (int'(v) >> i) % 2;
    endfunction

    function automatic int pick(logic [3:0] elig, int ptr);
        for (int k = 0; k < N; k++) begin
            if (bit_of(elig, (ptr + k) % N) == 1) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic side_t side_reset();
        side_t s;
        s.owner = -1; s.busy = 0; s.age = 0; s.ptr = 0; s.last = 0; s.tmo = 0;
        return s;
    endfunction

    function automatic side_t side_step(side_t s, logic [3:0] req, logic [3:0] en, bit start, bit done);
        side_t n;
        int    w;
        n = s;
        n.tmo = 0;
        if (s.owner < 0) begin
            w = pick(req & en, s.ptr);
            if (w >= 0) begin n.owner = w; n.last = w; n.busy = 0; n.age = 1; end
        end else if (s.busy && done) begin
            n.ptr = (s.owner + 1) % N;
            w = pick(req & en, n.ptr);
            if (w >= 0) begin n.owner = w; n.last = w; n.busy = 0; n.age = 1; end
            else n.owner = -1;
        end else if (s.age >= TMO - 1) begin
            n.owner = -1; n.ptr = (s.owner + 1) % N; n.tmo = 1;
        end else if (!s.busy && start) begin
            n.busy = 1; n.age = s.age + 1;
        end else if (!s.busy && (bit_of(req, s.owner) == 0 || bit_of(en, s.owner) == 0)) begin
            n.owner = -1;
        end else begin
            n.age = s.age + 1;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        rst = s_rst; ch_enable = s_en; r_req = s_rq; w_req = s_wq;
        r_start = s_rs; r_done = s_rd; w_start = s_ws; w_done = s_wd;
        if (s_rst) begin
            rsd = side_reset();
            wsd = side_reset();
        end else begin
            rsd = side_step(rsd, s_rq, s_en, s_rs, s_rd);
            wsd = side_step(wsd, s_wq, s_en, s_ws, s_wd);
        end
        e.rv = (rsd.owner >= 0) ? 1 : 0; e.rc = rsd.last; e.rt = rsd.tmo ? 1 : 0;
        e.wv = (wsd.owner >= 0) ? 1 : 0; e.wc = wsd.last; e.wt = wsd.tmo ? 1 : 0;
        sbq.push_back(e);
        started = 1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("r_grant_valid",    int'(r_grant_valid),    e.rv);
                    chk("r_active_channel", int'(r_active_channel), e.rc);
                    chk("r_timeout",        int'(r_timeout),        e.rt);
                    chk("w_grant_valid",    int'(w_grant_valid),    e.wv);
                    chk("w_active_channel", int'(w_active_channel), e.wc);
                    chk("w_timeout",        int'(w_timeout),        e.wt);
                end
            end
        end
    end

    initial begin
        int exp_order[5];
        rst = 1'b1; ch_enable = '0; r_req = '0; w_req = '0;
        r_start = 0; r_done = 0; w_start = 0; w_done = 0;
        rsd = side_reset(); wsd = side_reset();

        repeat (3) tick();
        after_edge();
        chk("reset_r_vld", int'(r_grant_valid), 0);
        chk("reset_w_vld", int'(w_grant_valid), 0);
        chk("reset_r_ch",  int'(r_active_channel), 0);

        // Single request on channel 2, then finish the burst
        s_rst = 0; s_en = 4'hF; s_rq = 4'b0100;
        tick(); after_edge();
        chk("dir_first_vld", int'(r_grant_valid), 1);
        chk("dir_first_ch",  int'(r_active_channel), 2);
        s_rs = 1; tick(); s_rs = 0;
        s_rq = 4'b0000; s_rd = 1; tick(); s_rd = 0; after_edge();
        chk("dir_done_idle", int'(r_grant_valid), 0);
        chk("dir_done_hold", int'(r_active_channel), 2);

        // Pointer now 3: all requesting gives 3, then 0,1,2,3,0 with no bubble
        s_rq = 4'b1111; tick(); after_edge();
        chk("dir_ptr3", int'(r_active_channel), 3);
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            s_rs = 1; tick(); s_rs = 0;
            s_rd = 1; tick(); s_rd = 0; after_edge();
            chk("dir_b2b_vld", int'(r_grant_valid), 1);
            chk("dir_b2b_ch",  int'(r_active_channel), exp_order[i]);
        end
        s_rq = 4'b0000;
        s_rs = 1; tick(); s_rs = 0;
        s_rd = 1; tick(); s_rd = 0;

        // Write side: only ch0 enabled, enable ch3 mid-burst
        s_wq = 4'b1001; s_en = 4'b0001; tick(); after_edge();
        chk("dir_w_ch0", int'(w_active_channel), 0);
        s_ws = 1; tick(); s_ws = 0;
        s_en = 4'b1001; tick();
        s_wd = 1; tick(); s_wd = 0; after_edge();
        chk("dir_w_vld", int'(w_grant_valid), 1);
        chk("dir_w_ch3", int'(w_active_channel), 3);
        s_wq = 4'b0000;
        s_ws = 1; tick(); s_ws = 0;
        s_wd = 1; tick(); s_wd = 0;
        s_en = 4'hF;

        // Watchdog: ch1 granted and never started
        s_rq = 4'b0010; tick();
        repeat (14) tick();
        after_edge();
        chk("dir_wd_pre_vld", int'(r_grant_valid), 1);
        chk("dir_wd_pre_tmo", int'(r_timeout), 0);
        tick(); after_edge();
        chk("dir_wd_tmo", int'(r_timeout), 1);
        chk("dir_wd_vld", int'(r_grant_valid), 0);
        s_rq = 4'b0110; tick(); after_edge();
        chk("dir_wd_ptr2", int'(r_active_channel), 2);

        // Withdraw before start keeps the pointer
        s_rq = 4'b0010; tick(); after_edge();
        chk("dir_drop_vld", int'(r_grant_valid), 0);
        s_rq = 4'b0110; tick(); after_edge();
        chk("dir_drop_ptr", int'(r_active_channel), 2);

        // Reset while both sides are busy
        s_wq = 4'b0001; s_rs = 1; tick(); s_rs = 0;
        s_ws = 1; tick(); s_ws = 0;
        s_rst = 1; tick(); s_rst = 0; after_edge();
        chk("dir_rst_r_vld", int'(r_grant_valid), 0);
        chk("dir_rst_w_vld", int'(w_grant_valid), 0);
        chk("dir_rst_w_ch",  int'(w_active_channel), 0);

        // Concurrent random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) s_rq = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) s_wq = 4'($urandom_range(0, 15));
            s_en  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            s_rs  = ($urandom_range(0, 2) == 0);
            s_rd  = ($urandom_range(0, 3) == 0);
            s_ws  = ($urandom_range(0, 2) == 0);
            s_wd  = ($urandom_range(0, 3) == 0);
            s_rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        @(posedge clk);
        #3;
        chk("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
